// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares one single-port memory between the fetch (IF) and
// data (MEM) ports. The data port has priority, and a streak limit keeps fetch
// from starving. A registered req/ack handshake goes to the memory, and a
// one-cycle ready pulse goes back to the requesting port.
module rv_mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       conflict_cnt
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned CNT_W    = 16;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t              state, state_nxt;
  logic [STREAK_W-1:0] d_streak;
  logic [CNT_W-1:0]    conflict_q;
  logic                if_live, dm_live;
  logic                grant_i, grant_d, contended;

  assign conflict_cnt = conflict_q;

  // A request is live unless its ready pulse is high this cycle, because that request has already been served.
  assign if_live = if_req & ~if_ready;
  assign dm_live = dm_req & ~dm_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grant decision and next state.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    contended = 1'b0;
    case (state)
      IDLE: begin
        contended = if_live & dm_live;
        if (dm_live && !(if_live && d_streak == STREAK_W'(MAX_D_STREAK))) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (if_live) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I:  if (mem_ack) state_nxt = IDLE;
      BUSY_D:  if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request registers, ready pulses and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (grant_i) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end
      if (mem_ack && state == BUSY_I) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        if_ready <= 1'b1;
        if_rdata <= mem_rdata;
      end
      if (mem_ack && state == BUSY_D) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        dm_ready <= 1'b1;
        if (!mem_we) dm_rdata <= mem_rdata;
      end
    end
  end

  // Count consecutive data grants that were made while fetch was waiting.
  // A data grant with fetch live implies d_streak < MAX_D_STREAK, so the counter cannot overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_streak <= '0;
    end else if (grant_i) begin
      d_streak <= '0;
    end else if (grant_d) begin
      if (if_live) d_streak <= d_streak + STREAK_W'(1);
      else         d_streak <= '0;
    end
  end

  // Saturating count of IDLE cycles in which both ports were contending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            conflict_q <= '0;
    else if (contended && conflict_q != {CNT_W{1'b1}})  conflict_q <= conflict_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed testbench for rv_mem_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_rv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_req, mem_we;
  logic [15:0] conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  rv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Both ports request in an otherwise quiet IDLE cycle. The port that loses is
  // withdrawn (a flushed request), so every round is exactly one contended grant.
  task automatic contend_round(input string tag, input logic exp_d, input logic [15:0] exp_cnt);
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h0000_0100; dm_addr = 32'h0000_0200;
    tick();
    chk({tag, " grant addr"}, mem_addr, exp_d ? 32'h0000_0200 : 32'h0000_0100);
    chk({tag, " conflict_cnt"}, 32'(conflict_cnt), 32'(exp_cnt));
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0000;
    if (exp_d) if_req = 1'b0;
    else       dm_req = 1'b0;
    tick();
    chk({tag, " dm_ready"}, 32'(dm_ready), 32'(exp_d));
    chk({tag, " if_ready"}, 32'(if_ready), 32'(!exp_d));
    mem_ack = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

    // Reset held while both ports request.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset readys", {30'd0, if_ready, dm_ready}, 32'd0);
      chk("reset conflict_cnt", 32'(conflict_cnt), 32'd0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    rst = 1'b0;

    // Single fetch, acknowledged in the first mem_req cycle.
    if_req = 1'b1; if_addr = 32'h0000_0010;
    tick();
    chk("fetch mem_req", 32'(mem_req), 32'd1);
    chk("fetch mem_we", 32'(mem_we), 32'd0);
    chk("fetch mem_addr", mem_addr, 32'h0000_0010);
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    chk("fetch if_ready", 32'(if_ready), 32'd1);
    chk("fetch if_rdata", if_rdata, 32'h0050_0093);
    chk("fetch mem_req drop", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    tick();
    chk("fetch ready one cycle", 32'(if_ready), 32'd0);
    chk("consumed req not regranted", 32'(mem_req), 32'd0);
    if_req = 1'b0;

    // Store whose ack arrives after three wait cycles.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0040; dm_wdata = 32'hDEAD_BEEF;
    tick();
    chk("store mem_addr", mem_addr, 32'h0000_0040);
    chk("store mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      chk("store mem_we held", 32'(mem_we), 32'd1);
      chk("store mem_req held", 32'(mem_req), 32'd1);
      chk("store no early ready", 32'(dm_ready), 32'd0);
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      end
      tick();
    end
    chk("store dm_ready", 32'(dm_ready), 32'd1);
    chk("store dm_rdata unchanged", dm_rdata, 32'd0);
    chk("store mem_we drop", 32'(mem_we), 32'd0);
    mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("store ready one cycle", 32'(dm_ready), 32'd0);

    // An ack while IDLE is ignored.
    mem_ack = 1'b1;
    tick();
    chk("idle ack ignored", {30'd0, if_ready, dm_ready}, 32'd0);
    mem_ack = 1'b0;

    // Load back the stored word.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0040;
    tick();
    chk("load mem_we", 32'(mem_we), 32'd0);
    chk("load mem_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("load dm_ready", 32'(dm_ready), 32'd1);
    chk("load dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    mem_ack = 1'b0; dm_req = 1'b0;
    tick();
    chk("no conflicts yet", 32'(conflict_cnt), 32'd0);

    // Both requests held: data wins once, then the ready-cycle rule alternates the ports.
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h0000_0100; dm_addr = 32'h0000_0200;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk("held grant addr", mem_addr, (g % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
      mem_ack = 1'b1;
      tick();
      chk("held dm_ready", 32'(dm_ready), 32'((g % 2) == 0));
      chk("held if_ready", 32'(if_ready), 32'((g % 2) == 1));
      mem_ack = 1'b0;
      if (g == 3) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    tick();
    chk("held idle", 32'(mem_req), 32'd0);
    chk("held conflict_cnt", 32'(conflict_cnt), 32'd1);

    // Starvation guard: the grant order is D,D,D,D,I,D,D,D,D,I.
    for (int r = 0; r < 10; r++)
      contend_round("streak", (r % 5) != 4, 16'(2 + r));

    // Reset while a load waits for its ack.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
    tick();
    chk("pre-reset mem_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async reset mem_req", 32'(mem_req), 32'd0);
    chk("async reset conflict_cnt", 32'(conflict_cnt), 32'd0);
    @(negedge clk);
    chk("reset no dm_ready", 32'(dm_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("reissue mem_req", 32'(mem_req), 32'd1);
    chk("reissue mem_addr", mem_addr, 32'h0000_0300);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0777;
    tick();
    chk("reissue dm_rdata", dm_rdata, 32'h0000_0777);
    mem_ack = 1'b0; dm_req = 1'b0;
    tick();

    // Saturation: preload the counter near the top instead of spending 65k contended rounds.
    force dut.conflict_q = 16'hFFFD;
    #1 release dut.conflict_q;
    contend_round("sat0", 1'b1, 16'hFFFE);
    contend_round("sat1", 1'b1, 16'hFFFF);
    contend_round("sat2", 1'b1, 16'hFFFF);
    contend_round("sat3", 1'b1, 16'hFFFF);
    chk("sat final", 32'(conflict_cnt), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
